// File: rtl/arb_mux_nch.sv
// arb_mux_nch: NCH input streams, each buffered in its own sync FIFO, merged round-robin onto one
//   valid/ready output stream with a channel-ID tag on every beat.
// Latency: a write at edge k into an idle block shows o_DataValid_D=1 after edge k+1.
// Backpressure: o_Full[c] per channel, and writes to a full channel are dropped. A stalled output
//   (valid & !ready) holds its data, ID and arbiter pointer.
// Optional feature macro: ARB_DROP_CNT_EN adds saturating per-channel drop counters on o_DropCnt.

// Single-clock FIFO with a combinational head read. The caller gates push with !full and pop with !empty.
// full is registered from the next-state count, so it reflects the state before each edge.
module arb_mux_nch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdat,
    output logic [WIDTH-1:0] rdat,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE      = 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      cnt;
    logic [AW:0]      cnt_next;

    // The extra pointer bit makes the occupancy 0..DEPTH unambiguous across wrap-around.
    assign cnt   = wr_ptr - rd_ptr;
    assign empty = (cnt == '0);
    assign rdat  = mem[rd_ptr[AW-1:0]];

    // Next occupancy. A simultaneous push and pop leaves the count unchanged.
    always_comb begin
        cnt_next = cnt;
        if (push && !pop) begin
            cnt_next = cnt + ONE;
        end else if (!push && pop) begin
            cnt_next = cnt - ONE;
        end
    end

    // Pointers and registered full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE;
            end
            full <= (cnt_next == FULL_CNT);
        end
    end

    // Storage has no reset. Only entries that were written are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wdat;
        end
    end
endmodule

module arb_mux_nch #(
    parameter int NCH   = 3,
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16,
    localparam int ID_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 CLK,
    input  logic                 ASynReset_N,
    input  logic [NCH-1:0]       i_DataValid,
    input  logic [NCH*WIDTH-1:0] i_DataIn,
    output logic [NCH-1:0]       o_Full,
    output logic                 o_DataValid_D,
    output logic [WIDTH-1:0]     o_DataOut_D,
    output logic [ID_W-1:0]      o_ChanId_D,
    input  logic                 i_DataReady_D
`ifdef ARB_DROP_CNT_EN
    ,
    output logic [NCH*CNT_W-1:0] o_DropCnt
`endif
);
    // Reject parameter sets the datapath cannot support.
    if (NCH < 2 || NCH > 16 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_param
        $error("arb_mux_nch: illegal parameter set");
    end

    logic             rst_n;
    logic [1:0]       rst_sync;
    logic [NCH-1:0]   push;
    logic [NCH-1:0]   pop;
    logic [NCH-1:0]   empty;
    logic [WIDTH-1:0] head [NCH];
    logic             ld;
    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  ptr;
    logic             found;
    int               idx;

    // RstGen: assertion is asynchronous and immediate. Release is aligned to CLK after two flops.
    always_ff @(posedge CLK or negedge ASynReset_N) begin
        if (!ASynReset_N) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    // One FIFO per channel. The write is accepted only if that channel was not full before the edge.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign push[c] = i_DataValid[c] & ~o_Full[c];
        assign pop[c]  = ld && (grant == ID_W'(c));

        arb_mux_nch_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (CLK),
            .rst_n (rst_n),
            .push  (push[c]),
            .pop   (pop[c]),
            .wdat  (i_DataIn[c*WIDTH +: WIDTH]),
            .rdat  (head[c]),
            .empty (empty[c]),
            .full  (o_Full[c])
        );
    end

    // Load when the output register is free (or is being drained this cycle) and some channel has data.
    assign ld = (!o_DataValid_D || i_DataReady_D) && !(&empty);

    // Round-robin search. Start just after the last grant, wrap mod NCH, and take the first non-empty channel.
    always_comb begin
        grant = ptr;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NCH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!found && !empty[ID_W'(idx)]) begin
                found = 1'b1;
                grant = ID_W'(idx);
            end
        end
    end

    // Output register and arbiter pointer. Both advance only on a load, so a stall freezes everything.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            o_DataValid_D <= 1'b0;
            o_DataOut_D   <= '0;
            o_ChanId_D    <= '0;
            ptr           <= ID_W'(NCH - 1);
        end else if (ld) begin
            o_DataValid_D <= 1'b1;
            o_DataOut_D   <= head[grant];
            o_ChanId_D    <= grant;
            ptr           <= grant;
        end else if (i_DataReady_D) begin
            o_DataValid_D <= 1'b0;
        end
    end

`ifdef ARB_DROP_CNT_EN
    // Per-channel count of writes lost to a full FIFO. The counter saturates and is cleared only by reset.
    for (genvar c = 0; c < NCH; c++) begin : g_drop
        logic [CNT_W-1:0] drop_cnt;

        // Count a dropped write unless the counter is already at its maximum.
        always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n) begin
                drop_cnt <= '0;
            end else if (i_DataValid[c] && o_Full[c] && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
        assign o_DropCnt[c*CNT_W +: CNT_W] = drop_cnt;
    end
`else
    // Without drop counters, writes to a full channel are discarded silently.
`endif
endmodule

// File: tb/tb_arb_mux_nch.sv
module tb_arb_mux_nch;
    localparam int NCH   = 3;
    localparam int W     = 64;
    localparam int DEPTH = 8;
    localparam int CW    = 16;
    localparam int IDW   = 2;
`ifdef ARB_DROP_CNT_EN
    localparam int OW = 1 + W + IDW + NCH + NCH*CW;
`else
    localparam int OW = 1 + W + IDW + NCH;
`endif

    logic             CLK = 1'b0;
    logic             ASynReset_N;
    logic [NCH-1:0]   i_DataValid;
    logic [NCH*W-1:0] i_DataIn;
    logic [NCH-1:0]   o_Full;
    logic             o_DataValid_D;
    logic [W-1:0]     o_DataOut_D;
    logic [IDW-1:0]   o_ChanId_D;
    logic             i_DataReady_D;
`ifdef ARB_DROP_CNT_EN
    logic [NCH*CW-1:0] o_DropCnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    arb_mux_nch #(.NCH(NCH), .WIDTH(W), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .CLK           (CLK),
        .ASynReset_N   (ASynReset_N),
        .i_DataValid   (i_DataValid),
        .i_DataIn      (i_DataIn),
        .o_Full        (o_Full),
        .o_DataValid_D (o_DataValid_D),
        .o_DataOut_D   (o_DataOut_D),
        .o_ChanId_D    (o_ChanId_D),
        .i_DataReady_D (i_DataReady_D)
`ifdef ARB_DROP_CNT_EN
        ,
        .o_DropCnt     (o_DropCnt)
`endif
    );

    // Behavioural reference: per-channel queues, one output slot, and the last granted channel.
    logic [W-1:0]   mq [NCH][$];
    logic           m_vld;
    logic [W-1:0]   m_dat;
    logic [IDW-1:0] m_id;
    int             m_ptr;
    int             m_drop [NCH];
    logic [IDW-1:0] acc_id [$];
    logic [W-1:0]   acc_dat [$];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            m_drop[c] = 0;
        end
        m_vld = 1'b0;
        m_dat = '0;
        m_id  = '0;
        m_ptr = NCH - 1;
    endtask

    function automatic logic [OW-1:0] obs();
        return {o_DataValid_D, o_DataOut_D, o_ChanId_D, o_Full
`ifdef ARB_DROP_CNT_EN
                , o_DropCnt
`endif
               };
    endfunction

    function automatic logic [OW-1:0] expv();
        logic [NCH-1:0] f;
`ifdef ARB_DROP_CNT_EN
        logic [NCH*CW-1:0] d;
`endif
        for (int c = 0; c < NCH; c++) f[c] = (mq[c].size() == DEPTH);
`ifdef ARB_DROP_CNT_EN
        for (int c = 0; c < NCH; c++) d[c*CW +: CW] = CW'(m_drop[c]);
        return {m_vld, m_dat, m_id, f, d};
`else
        return {m_vld, m_dat, m_id, f};
`endif
    endfunction

    function automatic bit model_idle();
        bit idle = !m_vld;
        for (int c = 0; c < NCH; c++) if (mq[c].size() != 0) idle = 0;
        return idle;
    endfunction

    // Advance the reference by one clock using the inputs now applied, then clock the DUT.
    task automatic tick();
        bit full_pre [NCH];
        bit any = 0;
        for (int c = 0; c < NCH; c++) begin
            full_pre[c] = (mq[c].size() == DEPTH);
            if (mq[c].size() != 0) any = 1;
        end
        if (o_DataValid_D && i_DataReady_D) begin
            acc_id.push_back(o_ChanId_D);
            acc_dat.push_back(o_DataOut_D);
        end
        if ((!m_vld || i_DataReady_D) && any) begin
            for (int k = 1; k <= NCH; k++) begin
                int g = (m_ptr + k) % NCH;
                if (mq[g].size() != 0) begin
                    m_dat = mq[g].pop_front();
                    m_id  = IDW'(g);
                    m_ptr = g;
                    break;
                end
            end
            m_vld = 1'b1;
        end else if (i_DataReady_D) begin
            m_vld = 1'b0;
        end
        for (int c = 0; c < NCH; c++) begin
            if (i_DataValid[c]) begin
                if (full_pre[c]) begin
                    if (m_drop[c] < (1 << CW) - 1) m_drop[c]++;
                end else begin
                    mq[c].push_back(i_DataIn[c*W +: W]);
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_data();
        for (int c = 0; c < NCH; c++) i_DataIn[c*W +: W] = {$urandom, $urandom};
    endtask

    task automatic release_rst();
        i_DataValid = '0;
        model_reset();
        @(posedge CLK);
        #1;
        ASynReset_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        i_DataValid   = '0;
        i_DataReady_D = 1'b0;
        ASynReset_N   = 1'b0;
        #1;
        release_rst();
        acc_id.delete();
        acc_dat.delete();
    endtask

    task automatic test_reset();
        i_DataValid   = '0;
        i_DataReady_D = 1'b0;
        i_DataIn      = '0;
        ASynReset_N   = 1'b1;
        #2;
        ASynReset_N = 1'b0;
        #1;
        n_chk++;
        if ({o_DataValid_D, o_DataOut_D, o_ChanId_D, o_Full} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: dut=%h required all zero", {o_DataValid_D, o_DataOut_D, o_ChanId_D, o_Full});
        end
        release_rst();
        n_chk++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL reset_release: dut=%h model=%h", obs(), expv());
        end
    endtask

    task automatic test_single();
        logic [W-1:0] a0 = 64'hA0;
        do_reset();
        i_DataReady_D = 1'b1;
        i_DataIn      = '0;
        i_DataIn[1*W +: W] = a0;
        i_DataValid   = 3'b010;
        tick();
        i_DataValid = '0;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL single cyc%0d: dut=%h model=%h", i, obs(), expv());
            end
            if (i == 1) begin
                n_chk++;
                if ({o_DataValid_D, o_DataOut_D, o_ChanId_D} !== {1'b1, a0, 2'd1}) begin
                    n_fail++;
                    $display("FAIL single_beat: vld=%0b dat=%h id=%0d required 1/a0/1", o_DataValid_D, o_DataOut_D, o_ChanId_D);
                end
            end
            if (i == 2) begin
                n_chk++;
                if (o_DataValid_D !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_drop_valid: vld=%0b required 0", o_DataValid_D);
                end
            end
            tick();
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            i_DataValid = 3'b111;
            rand_data();
            tick();
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL fair_fill cyc%0d: dut=%h model=%h", i, obs(), expv());
            end
        end
        i_DataValid   = '0;
        i_DataReady_D = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL fair_drain cyc%0d: dut=%h model=%h", i, obs(), expv());
            end
        end
        n_chk++;
        if (acc_id.size() != 12) begin
            n_fail++;
            $display("FAIL fair_count: beats=%0d required 12", acc_id.size());
        end
        for (int i = 0; i < 12 && i < acc_id.size(); i++) begin
            n_chk++;
            if (acc_id[i] !== IDW'(i % NCH)) begin
                n_fail++;
                $display("FAIL fair_id beat%0d: id=%0d required %0d", i, acc_id[i], i % NCH);
            end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] first0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            i_DataValid = 3'b111;
            rand_data();
            if (i == 0) first0 = i_DataIn[W-1:0];
            tick();
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL stall cyc%0d: dut=%h model=%h", i, obs(), expv());
            end
            if (i >= 1) begin
                n_chk++;
                if ({o_DataValid_D, o_DataOut_D, o_ChanId_D} !== {1'b1, first0, 2'd0}) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc%0d: vld=%0b dat=%h id=%0d required 1/%h/0", i, o_DataValid_D, o_DataOut_D, o_ChanId_D, first0);
                end
            end
        end
        n_chk++;
        if (o_Full !== 3'b111) begin
            n_fail++;
            $display("FAIL stall_full: full=%b required 111", o_Full);
        end
        i_DataValid   = '0;
        i_DataReady_D = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL stall_drain cyc%0d: dut=%h model=%h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        i_DataValid = 3'b010;
        rand_data();
        tick();
        i_DataValid = '0;
        tick();
        for (int i = 0; i < 11; i++) begin
            i_DataValid = 3'b001;
            rand_data();
            tick();
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL drop cyc%0d: dut=%h model=%h", i, obs(), expv());
            end
        end
        n_chk++;
        if (o_Full !== 3'b001) begin
            n_fail++;
            $display("FAIL drop_full: full=%b required 001", o_Full);
        end
`ifdef ARB_DROP_CNT_EN
        n_chk++;
        if (o_DropCnt !== {16'd0, 16'd0, 16'd3}) begin
            n_fail++;
            $display("FAIL drop_cnt: cnt=%h required ch0=3 others 0", o_DropCnt);
        end
`endif
        i_DataValid   = '0;
        i_DataReady_D = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL drop_drain cyc%0d: dut=%h model=%h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            i_DataValid   = 3'b111;
            i_DataReady_D = (i == 9);
            rand_data();
            tick();
        end
        n_chk++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL rstmid_pre: dut=%h model=%h", obs(), expv());
        end
        ASynReset_N = 1'b0;
        #1;
        n_chk++;
        if ({o_DataValid_D, o_Full} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_async: vld=%0b full=%b required 0/000", o_DataValid_D, o_Full);
        end
        release_rst();
        i_DataReady_D = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (o_DataValid_D !== 1'b0 || obs() !== expv()) begin
                n_fail++;
                $display("FAIL rstmid_idle cyc%0d: dut=%h model=%h", i, obs(), expv());
            end
        end
        i_DataValid = 3'b100;
        rand_data();
        tick();
        i_DataValid = '0;
        tick();
        n_chk++;
        if ({o_DataValid_D, o_ChanId_D} !== {1'b1, 2'd2} || obs() !== expv()) begin
            n_fail++;
            $display("FAIL rstmid_ch2: dut=%h model=%h required vld=1 id=2", obs(), expv());
        end
        i_DataReady_D = 1'b0;
        i_DataValid   = 3'b101;
        rand_data();
        tick();
        i_DataValid = '0;
        tick();
        i_DataReady_D = 1'b1;
        tick();
        n_chk++;
        if ({o_DataValid_D, o_ChanId_D} !== {1'b1, 2'd0} || obs() !== expv()) begin
            n_fail++;
            $display("FAIL rstmid_ch0_next: dut=%h model=%h required vld=1 id=0", obs(), expv());
        end
        repeat (3) tick();
    endtask

    task automatic test_push_pop();
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        do_reset();
        i_DataValid = 3'b011;
        rand_data();
        d1 = i_DataIn[1*W +: W];
        tick();
        i_DataValid = '0;
        tick();
        i_DataReady_D = 1'b1;
        i_DataValid   = 3'b010;
        rand_data();
        d2 = i_DataIn[1*W +: W];
        tick();
        i_DataValid = '0;
        n_chk++;
        if ({o_DataValid_D, o_DataOut_D, o_ChanId_D} !== {1'b1, d1, 2'd1} || obs() !== expv()) begin
            n_fail++;
            $display("FAIL pushpop_first: dut=%h model=%h required ch1 %h", obs(), expv(), d1);
        end
        tick();
        n_chk++;
        if ({o_DataValid_D, o_DataOut_D, o_ChanId_D} !== {1'b1, d2, 2'd1} || obs() !== expv()) begin
            n_fail++;
            $display("FAIL pushpop_again: dut=%h model=%h required ch1 %h", obs(), expv(), d2);
        end
        tick();
        n_chk++;
        if (o_DataValid_D !== 1'b0 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL pushpop_empty: dut=%h model=%h", obs(), expv());
        end
    endtask

    task automatic test_random();
        int drained;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            i_DataValid   = NCH'($urandom_range(0, 7));
            i_DataReady_D = ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 3 : 8));
            rand_data();
            tick();
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random cyc%0d: dut=%h model=%h", i, obs(), expv());
            end
        end
        i_DataValid   = '0;
        i_DataReady_D = 1'b1;
        drained = 0;
        for (int i = 0; i < 60 && !drained; i++) begin
            tick();
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random_drain cyc%0d: dut=%h model=%h", i, obs(), expv());
            end
            if (model_idle()) drained = 1;
        end
        n_chk++;
        if (!drained || o_DataValid_D !== 1'b0) begin
            n_fail++;
            $display("FAIL random_timeout: vld=%0b drained=%0d required 0/1", o_DataValid_D, drained);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_stall();
        test_drop();
        test_reset_mid();
        test_push_pop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
